// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-side definitions: next-PC select codes, NOP encoding and fetch FSM states.
// The hazard decision logic drives decision_in with these same codes.
package fetch_redirect_unit_pkg;

  localparam logic [2:0]  SEL_SEQ    = 3'b000;
  localparam logic [2:0]  SEL_BRANCH = 3'b001;
  localparam logic [2:0]  SEL_JAL    = 3'b010;
  localparam logic [2:0]  SEL_JALR   = 3'b011;
  localparam logic [31:0] NOP_ENC    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JAL) || (sel == SEL_JALR);
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch unit bundle: hazard decision/targets and IMEM data in, PC, IF/ID and status out.
interface fetch_redirect_unit_if #(parameter int CNT_W = 16);
  logic [2:0]       decision_in;
  logic             if_id_flush;
  logic             stall;
  logic [31:0]      branch_target;
  logic [31:0]      jal_target;
  logic [31:0]      jalr_target;
  logic [31:0]      instr_in;
  logic [31:0]      pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc;
  logic             if_id_valid;
  logic [CNT_W-1:0] redirect_cnt;
  logic             misalign_err;
  logic             illegal_sel;

  modport master (
    output decision_in, if_id_flush, stall, branch_target, jal_target, jalr_target, instr_in,
    input  pc, if_id_instr, if_id_pc, if_id_valid, redirect_cnt, misalign_err, illegal_sel
  );

  modport slave (
    input  decision_in, if_id_flush, stall, branch_target, jal_target, jalr_target, instr_in,
    output pc, if_id_instr, if_id_pc, if_id_valid, redirect_cnt, misalign_err, illegal_sel
  );
endinterface

// File: rtl/fetch_redirect_unit_next_pc_mux.sv
// Combinational next-PC select with redirect target alignment and illegal-code detection.
module fetch_redirect_unit_next_pc_mux
  import fetch_redirect_unit_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [31:0] req_pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] raw_target_s;

  // Select the redirect target, then apply redirect > stall replay > sequential priority.
  always_comb begin
    raw_target_s = 32'h0000_0000;
    redirect     = is_redirect(sel);
    case (sel)
      SEL_BRANCH: raw_target_s = branch_target;
      SEL_JAL:    raw_target_s = jal_target;
      SEL_JALR:   raw_target_s = jalr_target & 32'hFFFF_FFFE;
      default:    raw_target_s = 32'h0000_0000;
    endcase
    if (redirect) begin
      next_pc = {raw_target_s[31:2], 2'b00};
    end else if (stall) begin
      next_pc = req_pc;
    end else begin
      next_pc = pc + 32'd4;
    end
    // For JALR bit0 is already cleared, so only bit1 can flag here.
    misalign = redirect && (raw_target_s[1:0] != 2'b00);
    illegal  = sel[2];
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch stage: owns the PC, squashes wrong-path fetches after redirects, replays on stalls,
// loads IF/ID and counts taken redirects.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_redirect_unit_if.slave bus
);

  fetch_state_e     state_r;
  logic [31:0]      pc_r;
  logic [31:0]      req_pc_r;
  logic [31:0]      if_id_instr_r;
  logic [31:0]      if_id_pc_r;
  logic             if_id_valid_r;
  logic [CNT_W-1:0] redirect_cnt_r;
  logic             misalign_err_r;
  logic             illegal_sel_r;

  logic [31:0]      next_pc_s;
  logic             redirect_s;
  logic             misalign_s;
  logic             illegal_s;

  fetch_redirect_unit_next_pc_mux u_next_pc_mux (
    .sel           (bus.decision_in),
    .stall         (bus.stall),
    .pc            (pc_r),
    .req_pc        (req_pc_r),
    .branch_target (bus.branch_target),
    .jal_target    (bus.jal_target),
    .jalr_target   (bus.jalr_target),
    .next_pc       (next_pc_s),
    .redirect      (redirect_s),
    .misalign      (misalign_s),
    .illegal       (illegal_s)
  );

  // Fetch FSM plus PC and in-flight request address; BOOT and SQUASH both leave after one clean cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
    end else begin
      pc_r     <= next_pc_s;
      req_pc_r <= pc_r;
      if (redirect_s) begin
        state_r <= SQUASH;
      end else begin
        state_r <= RUN;
      end
    end
  end

  // IF/ID register: flush beats stall, stall beats the boot/squash bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr_r <= NOP_INSTR;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
    end else if (bus.if_id_flush || (!bus.stall && (state_r != RUN))) begin
      if_id_instr_r <= NOP_INSTR;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
    end else if (!bus.stall) begin
      if_id_instr_r <= bus.instr_in;
      if_id_pc_r    <= req_pc_r;
      if_id_valid_r <= 1'b1;
    end else begin
      if_id_instr_r <= if_id_instr_r;
      if_id_pc_r    <= if_id_pc_r;
      if_id_valid_r <= if_id_valid_r;
    end
  end

  // Saturating redirect counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_r <= {CNT_W{1'b0}};
      misalign_err_r <= 1'b0;
      illegal_sel_r  <= 1'b0;
    end else begin
      if (redirect_s && (redirect_cnt_r != {CNT_W{1'b1}})) begin
        redirect_cnt_r <= redirect_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        redirect_cnt_r <= redirect_cnt_r;
      end
      misalign_err_r <= misalign_err_r | misalign_s;
      illegal_sel_r  <= illegal_sel_r | illegal_s;
    end
  end

  assign bus.pc           = pc_r;
  assign bus.if_id_instr  = if_id_instr_r;
  assign bus.if_id_pc     = if_id_pc_r;
  assign bus.if_id_valid  = if_id_valid_r;
  assign bus.redirect_cnt = redirect_cnt_r;
  assign bus.misalign_err = misalign_err_r;
  assign bus.illegal_sel  = illegal_sel_r;

endmodule
